// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, serializer reset and pixel-domain reset from the PLL lock
// output; runs on the free-running reference clock.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned STAGGER_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lock,
  output logic       pll_reset,
  output logic       serdes_reset,
  output logic       pixel_reset,
  output logic       ready,
  output logic [7:0] relock_count
);

  localparam int unsigned MAX_A   = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned MAX_B   = (TIMEOUT_CYCLES > STAGGER_CYCLES) ? TIMEOUT_CYCLES : STAGGER_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_DONE  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

  typedef enum logic [2:0] {
    RST_PLL,
    WAIT_LOCK,
    STABLE,
    REL_SERDES,
    RUN,
    LOST
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [7:0]             relock_q, relock_d;
  logic                   pll_reset_q, pll_reset_d;
  logic                   serdes_reset_q, serdes_reset_d;
  logic                   pixel_reset_q, pixel_reset_d;
  logic                   ready_q, ready_d;
  logic                   lock_s;
  logic                   relock_inc;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], lock};
    state_d    = state_q;
    cnt_d      = cnt_q;
    relock_inc = 1'b0;

    unique case (state_q)
      RST_PLL: begin
        if (cnt_q == PLL_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = RST_PLL;
          cnt_d      = '0;
          relock_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE: begin
        // Counter holds the number of lock_s=1 cycles already seen, so the
        // release edge is the one after STABLE_CYCLES of them have been counted.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_DONE) begin
          state_d = REL_SERDES;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL_SERDES: begin
        if (!lock_s) begin
          state_d = LOST;
          cnt_d   = '0;
        end else if (cnt_q == STAGGER_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = LOST;
          cnt_d   = '0;
        end
      end
      LOST: begin
        state_d    = RST_PLL;
        cnt_d      = '0;
        relock_inc = 1'b1;
      end
      default: begin
        state_d = RST_PLL;
        cnt_d   = '0;
      end
    endcase

    relock_d = (relock_inc && (relock_q != 8'hFF)) ? relock_q + 8'd1 : relock_q;

    // Outputs are decoded from the next state so they change on the same edge as the state.
    pll_reset_d    = (state_d == RST_PLL);
    serdes_reset_d = !((state_d == REL_SERDES) || (state_d == RUN));
    pixel_reset_d  = (state_d != RUN);
    ready_d        = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= RST_PLL;
      cnt_q          <= '0;
      sync_q         <= '0;
      relock_q       <= '0;
      pll_reset_q    <= 1'b1;
      serdes_reset_q <= 1'b1;
      pixel_reset_q  <= 1'b1;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sync_q         <= sync_d;
      relock_q       <= relock_d;
      pll_reset_q    <= pll_reset_d;
      serdes_reset_q <= serdes_reset_d;
      pixel_reset_q  <= pixel_reset_d;
      ready_q        <= ready_d;
    end
  end

  assign pll_reset    = pll_reset_q;
  assign serdes_reset = serdes_reset_q;
  assign pixel_reset  = pixel_reset_q;
  assign ready        = ready_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lock = 1'b0;
  logic       pll_reset, serdes_reset, pixel_reset, ready;
  logic [7:0] relock_count;

  int n_cmp = 0;
  int n_err = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .STABLE_CYCLES (8),
    .TIMEOUT_CYCLES(32),
    .STAGGER_CYCLES(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lock        (lock),
    .pll_reset   (pll_reset),
    .serdes_reset(serdes_reset),
    .pixel_reset (pixel_reset),
    .ready       (ready),
    .relock_count(relock_count)
  );

  always #5 clk = ~clk;

  // Ordering invariants, sampled every cycle away from the active edge.
  always @(negedge clk) begin
    n_cmp++;
    if ((!pixel_reset && serdes_reset) || (ready !== !pixel_reset) || (pll_reset && !serdes_reset)) begin
      n_err++;
      $display("FAIL invariant @%0t: got pll=%b serdes=%b pixel=%b ready=%b, want ordered resets",
               $time, pll_reset, serdes_reset, pixel_reset, ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    lock  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic edges_to_pll_low(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (pll_reset && n < 100);
    if (pll_reset) n = -1;
  endtask

  task automatic edges_to_serdes_low(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (serdes_reset && n < 100);
    if (serdes_reset) n = -1;
  endtask

  task automatic edges_to_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < 100);
    if (!ready) n = -1;
  endtask

  // Lock raised at a negedge: 2 synchronizer edges, then cycle 0, then release
  // STABLE_CYCLES+1 = 9 edges later -> serdes low after the 12th edge.
  task automatic relock_and_check(input string tag, input logic [7:0] exp_relock);
    int n;
    lock = 1'b1;
    edges_to_serdes_low(n);
    n_cmp++;
    if (n !== 12) begin
      n_err++;
      $display("FAIL %s_serdes_edges: got %0d, want 12", tag, n);
    end
    edges_to_ready(n);
    n_cmp++;
    if (n !== 3) begin
      n_err++;
      $display("FAIL %s_ready_edges: got %0d, want 3", tag, n);
    end
    n_cmp++;
    if (relock_count !== exp_relock) begin
      n_err++;
      $display("FAIL %s_relock: got %0d, want %0d", tag, relock_count, exp_relock);
    end
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    n_cmp++;
    if ({pll_reset, serdes_reset, pixel_reset, ready, relock_count} !== 12'hE00) begin
      n_err++;
      $display("FAIL reset_values: got %h, want e00",
               {pll_reset, serdes_reset, pixel_reset, ready, relock_count});
    end
    edges_to_pll_low(n);
    n_cmp++;
    if (n !== 4) begin
      n_err++;
      $display("FAIL pll_pulse_width: got %0d, want 4", n);
    end
    for (int i = 0; i < 16; i++) tick();
    relock_and_check("first_lock", 8'd0);
  endtask

  task automatic test_loss_in_run();
    int n;
    lock = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({serdes_reset, ready} !== 2'b01) begin
      n_err++;
      $display("FAIL run_hold_before_lost: got %b, want 01", {serdes_reset, ready});
    end
    tick();
    n_cmp++;
    if ({pll_reset, serdes_reset, pixel_reset, ready} !== 4'b0110) begin
      n_err++;
      $display("FAIL run_lost_outputs: got %b, want 0110", {pll_reset, serdes_reset, pixel_reset, ready});
    end
    tick();
    n_cmp++;
    if ({pll_reset, relock_count} !== {1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL run_pll_relock: got pll=%b cnt=%0d, want pll=1 cnt=1", pll_reset, relock_count);
    end
    edges_to_pll_low(n);
    n_cmp++;
    if (n !== 4) begin
      n_err++;
      $display("FAIL run_repulse_width: got %0d, want 4", n);
    end
    relock_and_check("run_relock", 8'd1);
  endtask

  task automatic test_reset_in_run();
    n_cmp++;
    if ({ready, relock_count} !== {1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL pre_async_state: got ready=%b cnt=%0d, want ready=1 cnt=1", ready, relock_count);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({pll_reset, serdes_reset, pixel_reset, ready, relock_count} !== 12'hE00) begin
      n_err++;
      $display("FAIL async_reset_values: got %h, want e00",
               {pll_reset, serdes_reset, pixel_reset, ready, relock_count});
    end
    lock = 1'b0;
    @(negedge clk);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_glitch();
    int  n;
    bit  saw_pll;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    lock = 1'b1;
    n = 0;
    saw_pll = 0;
    do begin
      tick();
      n++;
      if (n == 6) lock = 1'b0;
      if (n == 7) lock = 1'b1;
      if (pll_reset) saw_pll = 1;
    end while (serdes_reset && n < 100);
    // lock_s low sampled at edge 9 (STABLE count 5), re-sampled high at edge 10, release 9 later.
    n_cmp++;
    if (n !== 19) begin
      n_err++;
      $display("FAIL glitch_release_edge: got %0d, want 19", n);
    end
    n_cmp++;
    if ({saw_pll, relock_count} !== {1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL glitch_no_repulse: got pll_seen=%b cnt=%0d, want 0 0", saw_pll, relock_count);
    end
  endtask

  task automatic test_loss_in_rel_serdes();
    int n;
    bit saw_ready;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    lock = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    lock = 1'b0;
    saw_ready = 0;
    tick();
    n_cmp++;
    if (serdes_reset !== 1'b0) begin
      n_err++;
      $display("FAIL rel_serdes_entered: got %b, want 0", serdes_reset);
    end
    tick();
    if (ready) saw_ready = 1;
    tick();
    if (ready) saw_ready = 1;
    n_cmp++;
    if ({pll_reset, serdes_reset, pixel_reset, ready} !== 4'b0110) begin
      n_err++;
      $display("FAIL rel_lost_outputs: got %b, want 0110", {pll_reset, serdes_reset, pixel_reset, ready});
    end
    tick();
    if (ready) saw_ready = 1;
    n_cmp++;
    if ({saw_ready, pll_reset, relock_count} !== {1'b0, 1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL rel_pll_relock: got ready_seen=%b pll=%b cnt=%0d, want 0 1 1",
               saw_ready, pll_reset, relock_count);
    end
    edges_to_pll_low(n);
    n_cmp++;
    if (n !== 4) begin
      n_err++;
      $display("FAIL rel_repulse_width: got %0d, want 4", n);
    end
    relock_and_check("rel_relock", 8'd1);
  endtask

  task automatic test_no_lock();
    bit prev_pll;
    bit changed;
    int rises;
    int last_rise;
    int falls;
    do_reset();
    prev_pll  = 1;
    changed   = 0;
    rises     = 0;
    last_rise = 0;
    falls     = 0;
    for (int c = 1; c <= 9600; c++) begin
      tick();
      if (!serdes_reset || ready) changed = 1;
      if (prev_pll && !pll_reset) begin
        falls++;
        if (falls <= 4) begin
          n_cmp++;
          if (c - last_rise !== 4) begin
            n_err++;
            $display("FAIL timeout_pulse_width_%0d: got %0d, want 4", falls, c - last_rise);
          end
        end
      end
      if (!prev_pll && pll_reset) begin
        rises++;
        last_rise = c;
        if (rises <= 3) begin
          n_cmp++;
          if ({c, relock_count} !== {36 * rises, 8'(rises)}) begin
            n_err++;
            $display("FAIL timeout_pulse_%0d: got edge=%0d cnt=%0d, want edge=%0d cnt=%0d",
                     rises, c, relock_count, 36 * rises, rises);
          end
        end
        if (rises == 255 || rises == 256) begin
          n_cmp++;
          if (relock_count !== 8'd255) begin
            n_err++;
            $display("FAIL relock_saturate_%0d: got %0d, want 255", rises, relock_count);
          end
        end
      end
      prev_pll = pll_reset;
    end
    n_cmp++;
    if ({changed, relock_count} !== {1'b0, 8'd255} || rises !== 266) begin
      n_err++;
      $display("FAIL timeout_final: got changed=%b cnt=%0d rises=%0d, want 0 255 266",
               changed, relock_count, rises);
    end
  endtask

  initial begin
    test_reset();
    test_loss_in_run();
    test_reset_in_run();
    test_glitch();
    test_loss_in_rel_serdes();
    test_no_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
